// File: rtl/ram_lcu_row_2p_bw.sv
// Two-port single-clock LCU-row neighbour line buffer with per-byte write masks and a hardware clear sequencer.
// Define RAM_LCU_ROW_OUT_REG_EN to add a second output register stage per port (read latency 2).
module ram_lcu_row_2p_bw #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int BYTE_WIDTH = 8,
    parameter logic [BYTE_WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               clr_i,
    output logic                               clr_busy_o,
    input  logic                               cena_i,
    input  logic                               wena_i,
    input  logic [WORD_WIDTH/BYTE_WIDTH-1:0]   bwena_i,
    input  logic [ADDR_WIDTH-1:0]              addra_i,
    input  logic [WORD_WIDTH-1:0]              dataa_i,
    output logic [WORD_WIDTH-1:0]              dataa_o,
    output logic                               vala_o,
    input  logic                               cenb_i,
    input  logic                               wenb_i,
    input  logic [WORD_WIDTH/BYTE_WIDTH-1:0]   bwenb_i,
    input  logic [ADDR_WIDTH-1:0]              addrb_i,
    input  logic [WORD_WIDTH-1:0]              datab_i,
    output logic [WORD_WIDTH-1:0]              datab_o,
    output logic                               valb_o
);
    // state   | meaning
    // IDLE    | normal two-port access
    // CLEAR   | sequencer fills one word per cycle; port writes dropped, reads see fill word
    localparam int NB    = WORD_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [WORD_WIDTH-1:0] FILL = {NB{CLR_VALUE}};

    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    clearing;

    logic [WORD_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wr_a, wr_b, rd_a, rd_b;
    logic [NB-1:0]           lane_a, lane_b;
    logic [WORD_WIDTH-1:0]   rd_word_a, rd_word_b;
    logic [WORD_WIDTH-1:0]   dataa_q, dataa_d, datab_q, datab_d;
    logic                    vala_q, valb_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clearing = (state_q == ST_CLEAR);
    end

    assign clr_busy_o = clearing;

    assign wr_a   = ~cena_i & ~wena_i & ~clearing;
    assign wr_b   = ~cenb_i & ~wenb_i & ~clearing;
    assign rd_a   = ~cena_i & wena_i;
    assign rd_b   = ~cenb_i & wenb_i;
    assign lane_a = {NB{wr_a}} & ~bwena_i;
    assign lane_b = {NB{wr_b}} & ~bwenb_i;

    // Port A lanes are applied last so they win a same-address collision.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem_q[clr_cnt_q] <= FILL;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (lane_b[k]) begin
                    mem_q[addrb_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= datab_i[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (lane_a[k]) begin
                    mem_q[addra_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= dataa_i[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Write-first: a read sees lanes the other port writes to the same address this cycle.
    always_comb begin
        rd_word_a = mem_q[addra_i];
        rd_word_b = mem_q[addrb_i];
        for (int k = 0; k < NB; k++) begin
            if (lane_b[k] && (addrb_i == addra_i)) begin
                rd_word_a[k*BYTE_WIDTH +: BYTE_WIDTH] = datab_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (lane_a[k] && (addra_i == addrb_i)) begin
                rd_word_b[k*BYTE_WIDTH +: BYTE_WIDTH] = dataa_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (clearing) begin
            rd_word_a = FILL;
            rd_word_b = FILL;
        end
    end

    assign dataa_d = rd_a ? rd_word_a : dataa_q;
    assign datab_d = rd_b ? rd_word_b : datab_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dataa_q <= '0;
            datab_q <= '0;
            vala_q  <= 1'b0;
            valb_q  <= 1'b0;
        end else begin
            dataa_q <= dataa_d;
            datab_q <= datab_d;
            vala_q  <= rd_a;
            valb_q  <= rd_b;
        end
    end

`ifdef RAM_LCU_ROW_OUT_REG_EN
    logic [WORD_WIDTH-1:0] dataa2_q, datab2_q;
    logic                  vala2_q, valb2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dataa2_q <= '0;
            datab2_q <= '0;
            vala2_q  <= 1'b0;
            valb2_q  <= 1'b0;
        end else begin
            dataa2_q <= vala_q ? dataa_q : dataa2_q;
            datab2_q <= valb_q ? datab_q : datab2_q;
            vala2_q  <= vala_q;
            valb2_q  <= valb_q;
        end
    end

    assign dataa_o = dataa2_q;
    assign datab_o = datab2_q;
    assign vala_o  = vala2_q;
    assign valb_o  = valb2_q;
`else
    assign dataa_o = dataa_q;
    assign datab_o = datab_q;
    assign vala_o  = vala_q;
    assign valb_o  = valb_q;
`endif

endmodule
